aq_djpeg_ycbcr2rgb_out: RTL and testbench

//  Downstream consumer of the YCbCr MCU bank memory: sweeps one 16x16 (4:2:0) MCU per bank and

---
 rtl/aq_djpeg_ycbcr2rgb_out_pkg.sv | 42 ++++
 rtl/aq_djpeg_ycbcr2rgb_out_if.sv | 20 ++
 rtl/aq_djpeg_rgb_fifo.sv | 62 ++++++
 rtl/aq_djpeg_ycbcr2rgb_out.sv | 165 ++++++++++++++++
 tb/tb_aq_djpeg_ycbcr2rgb_out.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aq_djpeg_ycbcr2rgb_out_pkg.sv
// Shared definitions for the YCbCr->RGB MCU output stage: Q8 colour coefficients, MCU geometry,
// FSM state encoding, the pixel record held in the output FIFO and the 8-bit clamp helper.
package aq_djpeg_ycbcr2rgb_out_pkg;

  // Q8 colour-conversion coefficients
  localparam logic signed [19:0] CoefRCr   = 20'sd359;
  localparam logic signed [19:0] CoefGCb   = 20'sd88;
  localparam logic signed [19:0] CoefGCr   = 20'sd183;
  localparam logic signed [19:0] CoefBCb   = 20'sd454;
  localparam logic signed [19:0] RoundHalf = 20'sd128;
  localparam logic signed [19:0] LevelShift = 20'sd128;

  localparam int unsigned McuPixels = 256;
  localparam int unsigned AddrW     = $clog2(McuPixels);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(McuPixels - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRead = 2'd1,
    StAdv  = 2'd2
  } state_e;

  // 56-bit FIFO entry
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } pixel_t;

  function automatic logic [7:0] clamp_u8(input logic signed [19:0] v);
    if (v < 0) begin
      return 8'd0;
    end else if (v > 20'sd255) begin
      return 8'd255;
    end else begin
      return v[7:0];
    end
  endfunction

endpackage

// File: rtl/aq_djpeg_ycbcr2rgb_out_if.sv
// Pixel output stream: valid/ready handshake carrying image coordinates and RGB.
interface aq_djpeg_ycbcr2rgb_out_if;
  logic        OutValid;
  logic        OutReady;
  logic [15:0] OutX;
  logic [15:0] OutY;
  logic [7:0]  OutR;
  logic [7:0]  OutG;
  logic [7:0]  OutB;

  modport master (
    output OutValid, OutX, OutY, OutR, OutG, OutB,
    input  OutReady
  );

  modport slave (
    input  OutValid, OutX, OutY, OutR, OutG, OutB,
    output OutReady
  );
endinterface

// File: rtl/aq_djpeg_rgb_fifo.sv
// Synchronous FIFO of pixel records with occupancy count. Head data reads as zero when empty so
// the stream outputs are clean after reset/flush. Depth must be a power of two.
module aq_djpeg_rgb_fifo
  import aq_djpeg_ycbcr2rgb_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CntW       = $clog2(FIFO_DEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push_i,
  input  pixel_t          wdata_i,
  input  logic            pop_i,
  output pixel_t          rdata_o,
  output logic [CntW-1:0] count_o
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  pixel_t          mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            pop;

  // Pointer and occupancy update; push and pop may coincide, even when full
  always_comb begin
    pop      = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)    rd_ptr_d = rd_ptr_q + PtrW'(1);
    unique case ({push_i, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: ;
    endcase
  end

  // Control state with synchronous flush
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Head entry and count
  always_comb begin
    rdata_o = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    count_o = count_q;
  end
endmodule

// File: rtl/aq_djpeg_ycbcr2rgb_out.sv
// Sweeps one 16x16 4:2:0 MCU per filled bank, converts YCbCr to RGB and streams pixels with
// image coordinates. Reads are credit-limited so the output FIFO can never overflow.
// Optional build macro AQ_DJPEG_EDGE_MASK_EN drops pixels outside the image (still read).
module aq_djpeg_ycbcr2rgb_out
  import aq_djpeg_ycbcr2rgb_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    DataInit,
  input  logic [15:0]             ImageWidth,
  input  logic [15:0]             ImageHeight,
  input  logic                    DataInEnable,
  output logic [AddrW-1:0]        DataInAddress,
  output logic                    DataInRead,
  input  logic signed [8:0]       DataInY,
  input  logic signed [8:0]       DataInCb,
  input  logic signed [8:0]       DataInCr,
  aq_djpeg_ycbcr2rgb_out_if.master out_if
);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e             state_q, state_d;
  logic [AddrW-1:0]   addr_q, addr_d;
  logic [15:0]        org_x_q, org_x_d, org_y_q, org_y_d;
  logic [16:0]        nx, ny;
  logic [CntW:0]      used;
  logic               issue;
  logic [15:0]        x_iss, y_iss;

  // Stage 1: RAM data arrives; stage 2: products registered
  logic               v1_q, v2_q;
  logic [15:0]        x1_q, y1_q, x2_q, y2_q;
  logic signed [19:0] yp1, rp1, gp1, bp1;
  logic signed [19:0] yp2_q, rp2_q, gp2_q, bp2_q;
  logic signed [19:0] r_sum, g_sum, b_sum;

  logic               flush, push, pop;
  pixel_t             push_data, head;
  logic [CntW-1:0]    fifo_count;

  assign flush = rst || DataInit;

  // Read credit, FSM next state and MCU origin advance
  always_comb begin
    // Everything already issued but not yet popped, plus this cycle's candidate
    used    = {1'b0, fifo_count} + {{CntW{1'b0}}, v1_q} + {{CntW{1'b0}}, v2_q};
    issue   = (state_q == StRead) && (used < (CntW+1)'(FIFO_DEPTH));
    state_d = state_q;
    addr_d  = addr_q;
    org_x_d = org_x_q;
    org_y_d = org_y_q;
    nx      = {1'b0, org_x_q} + 17'd16;
    ny      = {1'b0, org_y_q} + 17'd16;
    unique case (state_q)
      StIdle: if (DataInEnable) state_d = StRead;
      StRead: begin
        if (issue) begin
          addr_d = addr_q + AddrW'(1);
          if (addr_q == LastAddr) state_d = StAdv;
        end
      end
      StAdv: begin
        state_d = StIdle;
        if (nx >= {1'b0, ImageWidth}) begin
          org_x_d = '0;
          org_y_d = (ny >= {1'b0, ImageHeight}) ? '0 : ny[15:0];
        end else begin
          org_x_d = nx[15:0];
        end
      end
      default: state_d = StIdle;
    endcase
    // Address bits interleave into a 16x16 raster: x={a6,a2:a0}, y={a7,a5:a3}
    x_iss = org_x_q + {12'd0, addr_q[6], addr_q[2:0]};
    y_iss = org_y_q + {12'd0, addr_q[7], addr_q[5:3]};
  end

  // Level shift and coefficient products on the RAM output
  always_comb begin
    yp1 = 20'(DataInY) + LevelShift;
    rp1 = 20'(DataInCr) * CoefRCr;
    gp1 = 20'(DataInCb) * CoefGCb + 20'(DataInCr) * CoefGCr;
    bp1 = 20'(DataInCb) * CoefBCb;
  end

  // Round, sum, clamp and optional edge drop ahead of the FIFO
  always_comb begin
    r_sum       = yp2_q + ((rp2_q + RoundHalf) >>> 8);
    g_sum       = yp2_q - ((gp2_q + RoundHalf) >>> 8);
    b_sum       = yp2_q + ((bp2_q + RoundHalf) >>> 8);
    push_data.x = x2_q;
    push_data.y = y2_q;
    push_data.r = clamp_u8(r_sum);
    push_data.g = clamp_u8(g_sum);
    push_data.b = clamp_u8(b_sum);
`ifdef AQ_DJPEG_EDGE_MASK_EN
    push        = v2_q && (x2_q < ImageWidth) && (y2_q < ImageHeight);
`else
    push        = v2_q;
`endif
  end

  // FSM, origin and pipeline registers; DataInit abandons any MCU in progress
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q <= StIdle;
      addr_q  <= '0;
      org_x_q <= '0;
      org_y_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      yp2_q   <= '0;
      rp2_q   <= '0;
      gp2_q   <= '0;
      bp2_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      org_x_q <= org_x_d;
      org_y_q <= org_y_d;
      v1_q    <= issue;
      x1_q    <= x_iss;
      y1_q    <= y_iss;
      v2_q    <= v1_q;
      x2_q    <= x1_q;
      y2_q    <= y1_q;
      yp2_q   <= yp1;
      rp2_q   <= rp1;
      gp2_q   <= gp1;
      bp2_q   <= bp1;
    end
  end

  aq_djpeg_rgb_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .CntW       (CntW)
  ) u_fifo (
    .clk     (clk),
    .rst     (flush),
    .push_i  (push),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count)
  );

  // Read strobe and stream outputs
  always_comb begin
    DataInAddress   = addr_q;
    DataInRead      = issue;
    out_if.OutValid = (fifo_count != '0);
    out_if.OutX     = head.x;
    out_if.OutY     = head.y;
    out_if.OutR     = head.r;
    out_if.OutG     = head.g;
    out_if.OutB     = head.b;
    pop             = out_if.OutValid && out_if.OutReady;
  end
endmodule

// File: tb/tb_aq_djpeg_ycbcr2rgb_out.sv
// Directed bench for aq_djpeg_ycbcr2rgb_out: bank RAM model, pixel monitor and hand-computed
// expected pixels. Expected counts follow AQ_DJPEG_EDGE_MASK_EN when it is defined.
module tb_aq_djpeg_ycbcr2rgb_out;
  localparam int Depth = 4;
`ifdef AQ_DJPEG_EDGE_MASK_EN
  localparam int ETotal  = 1056;
  localparam int ECorner = 32;
`else
  localparam int ETotal  = 1792;
  localparam int ECorner = 256;
`endif

  typedef struct {int x; int y; int r; int g; int b;} px_t;

  logic              clk = 1'b0;
  logic              rst, DataInit, DataInEnable, DataInRead;
  logic [15:0]       ImageWidth, ImageHeight;
  logic [7:0]        DataInAddress;
  logic signed [8:0] DataInY, DataInCb, DataInCr;

  logic signed [8:0] y_mem [256];
  logic signed [8:0] cb_mem [256];
  logic signed [8:0] cr_mem [256];
  int exp_r [256];
  int exp_g [256];
  int exp_b [256];

  px_t pix_q [$];
  px_t held;
  logic prev_stall = 1'b0;
  int n_vec = 0, n_err = 0;
  int cyc = 0, mcus_left = 0;
  int rd_cnt = 0, acc_cnt = 0, ff_cnt = 0, max_outst = 0, unstable = 0;
  int first_rd_cyc = -1, first_val_cyc = -1, first_rd_addr = -1;

  aq_djpeg_ycbcr2rgb_out_if out_if ();

  aq_djpeg_ycbcr2rgb_out #(.FIFO_DEPTH(Depth)) dut (
    .clk           (clk),
    .rst           (rst),
    .DataInit      (DataInit),
    .ImageWidth    (ImageWidth),
    .ImageHeight   (ImageHeight),
    .DataInEnable  (DataInEnable),
    .DataInAddress (DataInAddress),
    .DataInRead    (DataInRead),
    .DataInY       (DataInY),
    .DataInCb      (DataInCb),
    .DataInCr      (DataInCr),
    .out_if        (out_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign DataInEnable = (mcus_left != 0);

  // Bank RAM: one cycle read latency
  always @(posedge clk) begin
    if (DataInRead) begin
      DataInY  <= y_mem[DataInAddress];
      DataInCb <= cb_mem[DataInAddress];
      DataInCr <= cr_mem[DataInAddress];
    end
  end

  // Monitor on the falling edge
  always @(negedge clk) begin
    if (prev_stall && (!out_if.OutValid || int'(out_if.OutX) != held.x ||
        int'(out_if.OutY) != held.y || int'(out_if.OutR) != held.r ||
        int'(out_if.OutG) != held.g || int'(out_if.OutB) != held.b)) unstable++;
    if (DataInRead) begin
      if (rd_cnt == 0) begin
        first_rd_cyc  = cyc;
        first_rd_addr = int'(DataInAddress);
      end
      rd_cnt++;
      if (DataInAddress == 8'hFF) begin
        ff_cnt++;
        if (mcus_left > 0) mcus_left--;
      end
    end
    if (rd_cnt - acc_cnt > max_outst) max_outst = rd_cnt - acc_cnt;
    if (out_if.OutValid && first_val_cyc < 0) first_val_cyc = cyc;
    if (out_if.OutValid && out_if.OutReady) begin
      pix_q.push_back('{int'(out_if.OutX), int'(out_if.OutY), int'(out_if.OutR),
                        int'(out_if.OutG), int'(out_if.OutB)});
      acc_cnt++;
    end
    prev_stall = out_if.OutValid && !out_if.OutReady;
    held = '{int'(out_if.OutX), int'(out_if.OutY), int'(out_if.OutR),
             int'(out_if.OutG), int'(out_if.OutB)};
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    pix_q.delete();
    rd_cnt = 0; acc_cnt = 0; ff_cnt = 0; max_outst = 0; unstable = 0;
    first_rd_cyc = -1; first_val_cyc = -1; first_rd_addr = -1;
  endtask

  task automatic load_uniform(input int y, input int cb, input int cr,
                              input int r, input int g, input int b);
    for (int i = 0; i < 256; i++) begin
      y_mem[i] = 9'(y); cb_mem[i] = 9'(cb); cr_mem[i] = 9'(cr);
      exp_r[i] = r; exp_g[i] = g; exp_b[i] = b;
    end
  endtask

  task automatic set_addr(input int a, input int y, input int cb, input int cr,
                          input int r, input int g, input int b);
    y_mem[a] = 9'(y); cb_mem[a] = 9'(cb); cr_mem[a] = 9'(cr);
    exp_r[a] = r; exp_g[a] = g; exp_b[a] = b;
  endtask

  task automatic pulse_init();
    DataInit = 1'b1;
    tick(1);
    DataInit = 1'b0;
  endtask

  task automatic wait_pix(input int n, input int budget);
    int k = 0;
    while (pix_q.size() < n && k < budget) begin
      tick(1);
      k++;
    end
    tick(8);
  endtask

  // One MCU in pix_q at origin (ox,oy): count, first pixel, values and coverage
  task automatic verify_mcu(input string tag, input int ox, input int oy);
    int bad = 0, dup = 0, dxi, dyi;
    bit seen [256];
    logic [3:0] dx, dy;
    logic [7:0] a;
    px_t p0;
    p0 = (pix_q.size() > 0) ? pix_q[0] : '{-1, -1, -1, -1, -1};
    check({tag, ".count"}, pix_q.size(), 256);
    check({tag, ".first_x"}, p0.x, ox);
    check({tag, ".first_y"}, p0.y, oy);
    foreach (pix_q[i]) begin
      dxi = pix_q[i].x - ox;
      dyi = pix_q[i].y - oy;
      if (dxi < 0 || dxi > 15 || dyi < 0 || dyi > 15) begin
        bad++;
      end else begin
        dx = 4'(dxi);
        dy = 4'(dyi);
        a = {dy[3], dx[3], dy[2:0], dx[2:0]};
        if (seen[a]) dup++;
        seen[a] = 1'b1;
        if (pix_q[i].r != exp_r[a] || pix_q[i].g != exp_g[a] || pix_q[i].b != exp_b[a]) bad++;
      end
    end
    check({tag, ".bad_pixels"}, bad, 0);
    check({tag, ".duplicates"}, dup, 0);
  endtask

  initial begin
    int ox_e [7] = '{0, 16, 32, 0, 16, 32, 0};
    int oy_e [7] = '{0, 0, 0, 16, 16, 16, 0};
    int org_q [$];
    int corner, k, found, g;

    rst = 1'b1; DataInit = 1'b0; out_if.OutReady = 1'b1;
    ImageWidth = 16'd64; ImageHeight = 16'd64;
    load_uniform(0, 0, 0, 128, 128, 128);
    tick(3);
    rst = 1'b0;
    tick(1);
    check("rst.read", DataInRead, 0);
    check("rst.addr", DataInAddress, 0);
    check("rst.valid", out_if.OutValid, 0);
    check("rst.x", out_if.OutX, 0);
    check("rst.y", out_if.OutY, 0);
    check("rst.rgb", {out_if.OutR, out_if.OutG, out_if.OutB}, 0);

    // Grey MCU and read-to-valid latency
    clear_stats();
    mcus_left = 1;
    wait_pix(256, 2000);
    check("a.latency", first_val_cyc - first_rd_cyc, 3);
    verify_mcu("a", 0, 0);

    // Red clamp high, from origin (0,0) after DataInit
    pulse_init();
    load_uniform(0, 0, 100, 255, 57, 128);
    clear_stats();
    mcus_left = 1;
    wait_pix(256, 2000);
    verify_mcu("b", 0, 0);

    // Low clamps; origin advanced to (16,0)
    load_uniform(-128, -128, 0, 0, 44, 0);
    clear_stats();
    mcus_left = 1;
    wait_pix(256, 2000);
    verify_mcu("c", 16, 0);

    // Mixed values with a 20-cycle back-pressure stall
    pulse_init();
    load_uniform(0, 0, 0, 128, 128, 128);
    set_addr(5, 50, -20, 30, 220, 163, 143);
    set_addr(77, -1, 1, -1, 126, 127, 129);
    set_addr(200, 255, 255, -256, 24, 255, 255);
    clear_stats();
    mcus_left = 1;
    k = 0;
    while (pix_q.size() < 50 && k < 1000) begin
      tick(1);
      k++;
    end
    out_if.OutReady = 1'b0;
    tick(20);
    out_if.OutReady = 1'b1;
    wait_pix(256, 2000);
    check("d.unstable", unstable, 0);
    check("d.max_inflight", max_outst, Depth);
    check("d.ff_reads", ff_cnt, 1);
    verify_mcu("d", 0, 0);

    // 40x20 image: origin sweep over 7 MCUs
    ImageWidth = 16'd40; ImageHeight = 16'd20;
    pulse_init();
    load_uniform(0, 0, 0, 128, 128, 128);
    clear_stats();
    mcus_left = 7;
    wait_pix(ETotal, 4000);
    check("e.total", pix_q.size(), ETotal);
    corner = 0;
    foreach (pix_q[i]) begin
      if (pix_q[i].x % 16 == 0 && pix_q[i].y % 16 == 0)
        org_q.push_back(pix_q[i].x * 65536 + pix_q[i].y);
      if (pix_q[i].x >= 32 && pix_q[i].y >= 16) corner++;
    end
    for (int i = 0; i < 7; i++) begin
      g = (i < org_q.size()) ? org_q[i] : -1;
      check($sformatf("e.origin%0d", i), g, ox_e[i] * 65536 + oy_e[i]);
    end
    check("e.corner_pixels", corner, ECorner);

    // DataInit mid-MCU (origin currently (16,0))
    clear_stats();
    mcus_left = 1;
    found = 0;
    k = 0;
    while (found == 0 && k < 2000) begin
      @(negedge clk);
      if (DataInRead && DataInAddress == 8'd100) found = 1;
      k++;
    end
    check("f.reach_addr100", found, 1);
    DataInit = 1'b1;
    @(posedge clk);
    #1;
    DataInit = 1'b0;
    check("f.read", DataInRead, 0);
    check("f.addr", DataInAddress, 0);
    check("f.valid", out_if.OutValid, 0);
    check("f.x", out_if.OutX, 0);
    clear_stats();
    wait_pix(256, 2000);
    check("f.first_addr", first_rd_addr, 0);
    check("f.ff_reads", ff_cnt, 1);
    verify_mcu("f", 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
